// File: rtl/exception_unit_pkg.sv
// Shared encodings for the exception sequencer: PC-source select codes,
// exception cause codes and the cause/vector helper functions.
package exception_unit_pkg;

   typedef enum logic [2:0] {
      PC_ALU      = 3'b000,
      PC_ALUOUT   = 3'b001,
      PC_INSTR    = 3'b010,
      PC_EPC      = 3'b011,
      PC_EXC      = 3'b100,
      PC_VEC_OPC  = 3'b101,
      PC_VEC_OVF  = 3'b110,
      PC_VEC_DIV0 = 3'b111
   } pc_src_t;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'b00,
      CAUSE_OPCODE   = 2'b01,
      CAUSE_OVERFLOW = 2'b10,
      CAUSE_DIV0     = 2'b11
   } cause_t;

   localparam int unsigned CNT_W = 4;

   // Opcode beats overflow beats divide-by-zero.
   function automatic cause_t prio_cause(input logic opc, input logic ovf, input logic div0);
      if (opc)
         return CAUSE_OPCODE;
      else if (ovf)
         return CAUSE_OVERFLOW;
      else if (div0)
         return CAUSE_DIV0;
      else
         return CAUSE_NONE;
   endfunction

   function automatic pc_src_t vec_source(input cause_t cause);
      case (cause)
         CAUSE_OPCODE:   return PC_VEC_OPC;
         CAUSE_OVERFLOW: return PC_VEC_OVF;
         CAUSE_DIV0:     return PC_VEC_DIV0;
         default:        return PC_ALU;
      endcase
   endfunction

endpackage

// File: rtl/exception_unit.sv
// Exception entry/return sequencer: saves EPC, vectors through slots 253..255,
// fetches the handler byte, then jumps; rte restores PC from EPC.
module exception_unit
   import exception_unit_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exc_opcode,
   input  logic        exc_overflow,
   input  logic        exc_div0,
   input  logic        rte,
   input  logic [31:0] pc_in,
   input  logic [31:0] mem_data_in,
   output logic        exc_active,
   output logic [2:0]  pc_source,
   output logic        pc_write,
   output logic        mem_read,
   output logic [31:0] epc,
   output logic [31:0] exc_target,
   output logic [1:0]  exc_cause
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SET_VEC,
      S_MEM_WAIT,
      S_JUMP,
      S_RETURN
   } state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] wait_cnt;
   logic             any_exc;
   cause_t           cause_reg;
   logic [23:0]      unused_mem_bits;

   assign any_exc         = exc_opcode | exc_overflow | exc_div0;
   assign exc_cause       = cause_reg;
   assign unused_mem_bits = mem_data_in[31:8];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         epc        <= '0;
         exc_target <= '0;
         cause_reg  <= CAUSE_NONE;
         wait_cnt   <= '0;
      end else begin
         state <= next_state;
         case (state)
            S_IDLE: begin
               if (any_exc) begin
                  epc       <= pc_in - 32'd4;
                  cause_reg <= prio_cause(exc_opcode, exc_overflow, exc_div0);
               end
            end
            S_SET_VEC: wait_cnt <= CNT_W'(MEM_LATENCY - 1);
            S_MEM_WAIT: begin
               if (wait_cnt == '0)
                  exc_target <= {24'b0, mem_data_in[7:0]};
               else
                  wait_cnt <= wait_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Outputs decode only the registered state and cause, never the inputs.
   always_comb begin
      next_state = state;
      exc_active = 1'b1;
      pc_source  = PC_ALU;
      pc_write   = 1'b0;
      mem_read   = 1'b0;
      case (state)
         S_IDLE: begin
            exc_active = 1'b0;
            if (any_exc)
               next_state = S_SET_VEC;
            else if (rte)
               next_state = S_RETURN;
         end
         S_SET_VEC: begin
            pc_source  = vec_source(cause_reg);
            pc_write   = 1'b1;
            next_state = S_MEM_WAIT;
         end
         S_MEM_WAIT: begin
            mem_read = 1'b1;
            if (wait_cnt == '0)
               next_state = S_JUMP;
         end
         S_JUMP: begin
            pc_source  = PC_EXC;
            pc_write   = 1'b1;
            next_state = S_IDLE;
         end
         S_RETURN: begin
            pc_source  = PC_EPC;
            pc_write   = 1'b1;
            next_state = S_IDLE;
         end
         default: begin
            exc_active = 1'b0;
            next_state = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_exception_unit.sv
// Scoreboard bench for exception_unit: stimulus pushes the expected busy-cycle
// outputs, a negedge monitor pops one entry per exc_active cycle.
module tb_exception_unit;

   localparam int unsigned LAT = 2;

   typedef struct {
      logic        active;
      logic [2:0]  src;
      logic        pw;
      logic        mr;
      logic [31:0] epc;
      logic [31:0] target;
      logic [1:0]  cause;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        exc_opcode = 1'b0, exc_overflow = 1'b0, exc_div0 = 1'b0, rte = 1'b0;
   logic [31:0] pc_in = '0, mem_data_in = '0;
   logic        exc_active, pc_write, mem_read;
   logic [2:0]  pc_source;
   logic [31:0] epc, exc_target;
   logic [1:0]  exc_cause;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] m_epc = '0, m_target = '0;
   logic [1:0]  m_cause = '0;

   exception_unit #(.MEM_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
      .rte(rte), .pc_in(pc_in), .mem_data_in(mem_data_in),
      .exc_active(exc_active), .pc_source(pc_source), .pc_write(pc_write),
      .mem_read(mem_read), .epc(epc), .exc_target(exc_target), .exc_cause(exc_cause)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [2:0] src, input logic pw, input logic mr);
      exp_t e;
      e.active = 1'b1; e.src = src; e.pw = pw; e.mr = mr;
      e.epc = m_epc; e.target = m_target; e.cause = m_cause;
      return e;
   endfunction

   // Monitor: one scoreboard entry per busy cycle.
   always @(negedge clk) begin
      if (reset && exc_active) begin
         if (exp_q.size() == 0) begin
            check("unexpected_busy_cycle", {125'b0, pc_source}, 128'h0);
            check("unexpected_busy_active", {127'b0, exc_active}, 128'h0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("busy_cycle",
                  {53'b0, exc_active, pc_source, pc_write, mem_read, epc, exc_target, exc_cause},
                  {53'b0, e.active, e.src, e.pw, e.mr, e.epc, e.target, e.cause});
         end
      end
   end

   // Flags are driven just after a rising edge and sampled on the next one.
   task automatic do_exception(input logic opc, input logic ovf, input logic dz, input logic with_rte,
                               input logic [31:0] pc, input logic [31:0] data, input logic rte_mid,
                               input logic [1:0] cause, input logic [2:0] vec);
      m_epc   = pc - 32'd4;
      m_cause = cause;
      exp_q.push_back(mk(vec, 1'b1, 1'b0));
      for (int unsigned i = 0; i < LAT; i++) exp_q.push_back(mk(3'b000, 1'b0, 1'b1));
      m_target = {24'b0, data[7:0]};
      exp_q.push_back(mk(3'b100, 1'b1, 1'b0));
      pc_in = pc; mem_data_in = data;
      exc_opcode = opc; exc_overflow = ovf; exc_div0 = dz; rte = with_rte;
      @(posedge clk); #1;
      exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0; rte = 1'b0;
      for (int i = 0; i < int'(LAT) + 2; i++) begin
         @(posedge clk); #1;
         rte = rte_mid && (i == 0);
      end
      rte = 1'b0;
   endtask

   task automatic do_return();
      exp_q.push_back(mk(3'b011, 1'b1, 1'b0));
      rte = 1'b1;
      @(posedge clk); #1;
      rte = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #2;
      check("reset_ctrl", {122'b0, exc_active, pc_source, pc_write, mem_read}, 128'h0);
      check("reset_regs", {30'b0, epc, exc_target, exc_cause}, 128'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      do_exception(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'hFFFF_FF88, 1'b0, 2'b10, 3'b110);
      check("ovf_epc", {96'b0, epc}, {96'b0, 32'h0000_003C});
      check("ovf_target", {96'b0, exc_target}, {96'b0, 32'h0000_0088});
      check("ovf_cause", {126'b0, exc_cause}, {126'b0, 2'b10});
      repeat (2) @(posedge clk);
      #1;

      do_return();
      check("ret_idle", {127'b0, exc_active}, 128'h0);

      do_exception(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0012, 1'b0, 2'b01, 3'b101);
      check("prio_cause", {126'b0, exc_cause}, {126'b0, 2'b01});

      // Back-to-back entry, rte ignored both when simultaneous and mid-wait.
      do_exception(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h1234_5677, 1'b1, 2'b11, 3'b111);
      check("wrap_epc", {96'b0, epc}, {96'b0, 32'hFFFF_FFFC});
      check("div0_target", {96'b0, exc_target}, {96'b0, 32'h0000_0077});
      repeat (3) @(posedge clk);
      #1;

      // Reset during MEM_WAIT.
      m_epc = 32'h0000_0020; m_cause = 2'b10;
      exp_q.push_back(mk(3'b110, 1'b1, 1'b0));
      pc_in = 32'h0000_0024; exc_overflow = 1'b1;
      @(posedge clk); #1;
      exc_overflow = 1'b0;
      @(posedge clk); #1;
      check("pre_reset_memwait", {127'b0, mem_read}, {127'b0, 1'b1});
      reset = 1'b0;
      #1;
      check("midreset_ctrl", {122'b0, exc_active, pc_source, pc_write, mem_read}, 128'h0);
      check("midreset_regs", {30'b0, epc, exc_target, exc_cause}, 128'h0);
      m_epc = '0; m_target = '0; m_cause = '0;
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         check("post_reset_nowrite", {126'b0, pc_write, exc_active}, 128'h0);
      end

      check("scoreboard_drained", 128'(exp_q.size()), 128'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/exception_unit.md
# exception_unit

Sequencer for exception entry and return in the multicycle CPU. It sits upstream of the PC-source selector and the PC register. On an invalid-opcode, overflow or divide-by-zero flag it:
- saves EPC;
- steers the PC to the matching vector slot (253/254/255);
- reads the handler address byte from memory;
- jumps to it.

On `rte` it restores the PC from EPC. While `exc_active` is high the control unit yields PC source, PC write and memory-read control to this block.

## Interface
- `MEM_LATENCY`, default 2: cycles `mem_read` is held before `mem_data_in` is valid. Range is 1..15.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `exc_opcode` input 1: invalid-opcode flag, sampled in IDLE.
- `exc_overflow` input 1: ALU overflow flag, sampled in IDLE.
- `exc_div0` input 1: divide-by-zero flag, sampled in IDLE.
- `rte` input 1: return-from-exception request, sampled in IDLE.
- `pc_in` input 32: current PC register value, already incremented by 4.
- `mem_data_in` input 32: memory read data. Bits [7:0] carry the handler address.
- `exc_active` output 1: this block owns PC/memory control this cycle.
- `pc_source` output 3: select code to the PC-source selector.
- `pc_write` output 1: PC register write enable.
- `mem_read` output 1: memory read request at address = PC.
- `epc` output 32: EPC register, feeds selector input 3.
- `exc_target` output 32: zero-extended handler address, feeds selector input 4.
- `exc_cause` output 2: last cause taken. 01 = opcode, 10 = overflow, 11 = div0, 00 = none.

## Operation
- States: IDLE, SET_VEC, MEM_WAIT, JUMP, RETURN.
- **IDLE**
  - If any exception flag is high:
    - cause ← highest priority flag; priority is opcode > overflow > div0;
    - `epc` ← `pc_in` − 4, modulo 2^32;
    - go to SET_VEC.
  - Otherwise, if `rte` is high, go to RETURN.
  - Exception flags win over a simultaneous `rte`.
- **SET_VEC** (1 cycle)
  - `pc_write` = 1.
  - `pc_source` = 101 for opcode, 110 for overflow, 111 for div0.
  - Load the wait counter with `MEM_LATENCY` − 1, then go to MEM_WAIT.
- **MEM_WAIT** (`MEM_LATENCY` cycles)
  - `mem_read` = 1.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: `exc_target` ← {24'b0, `mem_data_in[7:0]`}, then go to JUMP.
- **JUMP** (1 cycle): `pc_source` = 100, `pc_write` = 1, then go to IDLE.
- **RETURN** (1 cycle): `pc_source` = 011, `pc_write` = 1, then go to IDLE.
- Exception flags and `rte` outside IDLE are ignored and not queued.
- Default outputs (IDLE): `pc_source` = 000, `pc_write` = 0, `mem_read` = 0, `exc_active` = 0.
- `exc_active` = 1 in every non-IDLE state.
- `epc`, `exc_target` and `exc_cause` hold their values until overwritten by the next exception entry.
- `exc_cause` updates on the entry edge.

## Timing
- Reset (asynchronous, active-low):
  - state = IDLE;
  - `epc` = 0, `exc_target` = 0, `exc_cause` = 00, counter = 0;
  - all control outputs = 0.
- Reset asserted mid-sequence aborts it immediately. No partial PC write follows release.
- Flag high in IDLE at edge T:
  - SET_VEC during cycle T+1;
  - MEM_WAIT during T+2 .. T+1+`MEM_LATENCY`;
  - JUMP during T+2+`MEM_LATENCY`;
  - IDLE again at T+3+`MEM_LATENCY`.
- Total exception entry is `MEM_LATENCY` + 2 busy cycles.
- `rte` high in IDLE at edge T: RETURN during T+1, IDLE at T+2.
- All outputs are registered state decodes. There is no combinational path from inputs to outputs.
- Back-to-back: a flag high in the first IDLE cycle after JUMP or RETURN is accepted normally.

## Structure
- Shared package/include holds:
  - PC-source encodings: ALU 000, ALUOUT 001, INSTR 010, EPC 011, EXC 100, VEC_OPC 101, VEC_OVF 110, VEC_DIV0 111;
  - the `exc_cause` codes.
- State encoding stays local to the block.
- Single module; the wait counter is inline. No sub-module.

## Test plan
- Reset mid-sequence: assert `reset` = 0 during MEM_WAIT → all outputs 0 immediately; after release, state is IDLE and no `pc_write` occurs.
- Overflow entry:
  - Stimulus: `MEM_LATENCY` = 2, `pc_in` = 0x0000_0040, `exc_overflow` pulsed, `mem_data_in` = 0xFFFF_FF88.
  - Response: `epc` = 0x3C, `exc_cause` = 10, `pc_source` = 110 with `pc_write` at T+1, `mem_read` at T+2..T+3, then `pc_source` = 100 with `pc_write` at T+4, `exc_target` = 0x88.
- Priority: opcode, overflow and div0 all high together → `exc_cause` = 01, vector `pc_source` = 101.
- Simultaneous and in-flight requests:
  - `rte` together with `exc_div0` → exception taken, `pc_source` = 111.
  - `rte` pulsed during MEM_WAIT → ignored.
- Return: `rte` alone in IDLE with `epc` = 0x3C → `pc_source` = 011 and `pc_write` for exactly one cycle, `exc_active` for one cycle.
- Wrap-around: `pc_in` = 0x0000_0000 on exception → `epc` = 0xFFFF_FFFC.
